// File: rtl/log_trigger.sv
// log_trigger: masked-match capture front-end for the diagnostic logger.
// Emits change-compressed, delta-timestamped words, then starts the drain.
module log_trigger #(
    parameter int PROBE_WIDTH = 28,
    parameter int DEPTH       = 512,
    parameter int CNT_WIDTH   = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PROBE_WIDTH-1:0] probe,
    input  logic                   probe_valid,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [PROBE_WIDTH-1:0] trig_mask,
    input  logic [PROBE_WIDTH-1:0] trig_value,
    input  logic [CNT_WIDTH-1:0]   post_count,
    output logic                   log_wr_en,
    output logic [PROBE_WIDTH+7:0] log_data,
    output logic                   log_rd_start,
    output logic [1:0]             state,
    output logic [CNT_WIDTH-1:0]   word_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    state_t                 state_q;
    state_t                 state_d;
    logic [PROBE_WIDTH-1:0] last_q;
    logic [7:0]             delta_q;
    logic [7:0]             wr_delta;
    logic [CNT_WIDTH-1:0]   limit_q;
    logic [CNT_WIDTH-1:0]   limit_new;
    logic                   trig;
    logic                   changed;
    logic                   wr;
    logic                   load;
    logic                   finish;

    assign trig      = probe_valid &&
                       (((probe ^ trig_value) & trig_mask) == '0);
    assign changed   = (probe != last_q) || (delta_q == 8'hFF);
    assign limit_new = (post_count == '0 || post_count > DEPTH_C) ?
                       DEPTH_C : post_count;
    assign state     = state_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle write/arm/finish decisions.
    // The final write is visible one cycle before DONE, so rd_start
    // lands on the first DONE cycle, after the last log_wr_en.
    always_comb begin
        state_d  = state_q;
        wr       = 1'b0;
        wr_delta = delta_q;
        load     = 1'b0;
        finish   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (abort && arm) begin
                    state_d = IDLE;
                end else if (arm) begin
                    state_d = ARMED;
                    load    = 1'b1;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (trig) begin
                    state_d  = CAPTURE;
                    wr       = 1'b1;
                    wr_delta = 8'd0;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (word_cnt == limit_q) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end else if (probe_valid && changed) begin
                    wr = 1'b1;
                end
            end
        endcase
    end

    // Registered logger interface and capture datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log_wr_en    <= 1'b0;
            log_data     <= '0;
            log_rd_start <= 1'b0;
            word_cnt     <= '0;
            delta_q      <= '0;
            last_q       <= '0;
            limit_q      <= '0;
        end else begin
            log_wr_en    <= wr;
            log_rd_start <= finish;
            if (wr) begin
                log_data <= {wr_delta, probe};
                last_q   <= probe;
            end
            if (load) begin
                word_cnt <= '0;
                delta_q  <= '0;
                limit_q  <= limit_new;
            end else if (wr) begin
                word_cnt <= word_cnt + 1'b1;
                delta_q  <= 8'd1;
            end else if (state_q == CAPTURE && delta_q != 8'hFF) begin
                delta_q <= delta_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_log_trigger.sv
// tb_log_trigger: directed bench for log_trigger.
// Inputs driven and outputs sampled on the falling edge.
module tb_log_trigger;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] probe;
    logic        probe_valid;
    logic        arm;
    logic        abort;
    logic [27:0] trig_mask;
    logic [27:0] trig_value;
    logic [9:0]  post_count;
    logic        log_wr_en;
    logic [35:0] log_data;
    logic        log_rd_start;
    logic [1:0]  state;
    logic [9:0]  word_cnt;

    int errors = 0;
    int checks = 0;

    log_trigger dut (
        .clk         (clk),
        .rst         (rst),
        .probe       (probe),
        .probe_valid (probe_valid),
        .arm         (arm),
        .abort       (abort),
        .trig_mask   (trig_mask),
        .trig_value  (trig_value),
        .post_count  (post_count),
        .log_wr_en   (log_wr_en),
        .log_data    (log_data),
        .log_rd_start(log_rd_start),
        .state       (state),
        .word_cnt    (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_arm(input logic [9:0] pc);
        post_count = pc;
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        probe = '0;
        probe_valid = 1'b0;
        arm = 1'b0;
        abort = 1'b0;
        trig_mask = '0;
        trig_value = '0;
        post_count = '0;
        step();
        step();
        checks++;
        if (state !== 2'd0 || log_wr_en !== 1'b0 || log_data !== 36'd0 ||
            log_rd_start !== 1'b0 || word_cnt !== 10'd0) begin
            errors++;
            $display("FAIL reset: st=%0d wr=%b d=%h rs=%b wc=%0d want all 0",
                     state, log_wr_en, log_data, log_rd_start, word_cnt);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [35:0] exp;
        do_arm(10'd4);
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL basic_armed: state=%0d want 1", state);
        end
        probe_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            probe = 28'(i);
            // arm mid-capture must not relatch the limit
            if (i == 3) begin
                arm = 1'b1;
                post_count = 10'd1;
            end
            step();
            arm = 1'b0;
            exp = {(i == 1) ? 8'd0 : 8'd1, 28'(i)};
            checks++;
            if (log_wr_en !== 1'b1 || log_data !== exp ||
                word_cnt !== 10'(i) || log_rd_start !== 1'b0) begin
                errors++;
                $display("FAIL basic_w%0d: wr=%b d=%h wc=%0d rs=%b want 1 %h %0d 0",
                         i, log_wr_en, log_data, word_cnt, log_rd_start, exp, i);
            end
        end
        probe = 28'd9;
        step();
        checks++;
        if (log_rd_start !== 1'b1 || state !== 2'd3 || log_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: rs=%b st=%0d wr=%b want 1 3 0",
                     log_rd_start, state, log_wr_en);
        end
        step();
        checks++;
        if (log_rd_start !== 1'b0 || log_data !== {8'd1, 28'd4}) begin
            errors++;
            $display("FAIL basic_hold: rs=%b d=%h want 0 %h",
                     log_rd_start, log_data, {8'd1, 28'd4});
        end
        probe_valid = 1'b0;
    endtask

    task automatic test_mask();
        int nwr = 0;
        int first_i = -1;
        int nrs = 0;
        logic [35:0] first_d = '0;
        trig_mask = 28'hF;
        trig_value = 28'h5;
        do_arm(10'd1);
        probe_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            probe = 28'(i % 16);
            step();
            if (log_wr_en) begin
                if (nwr == 0) begin
                    first_i = i;
                    first_d = log_data;
                end
                nwr++;
            end
            if (log_rd_start) nrs++;
        end
        checks++;
        if (first_i != 5 || first_d !== {8'd0, 28'd5} || nwr != 1) begin
            errors++;
            $display("FAIL mask_first: at=%0d d=%h n=%0d want 5 %h 1",
                     first_i, first_d, nwr, {8'd0, 28'd5});
        end
        checks++;
        if (nrs != 1 || state !== 2'd3) begin
            errors++;
            $display("FAIL mask_done: rs=%0d st=%0d want 1 3", nrs, state);
        end
        probe_valid = 1'b0;
        trig_mask = '0;
        trig_value = '0;
    endtask

    task automatic test_keepalive();
        int wk[$];
        logic [35:0] wd[$];
        int rs_k = -1;
        do_arm(10'd3);
        probe_valid = 1'b1;
        probe = 28'hABC;
        for (int k = 1; k <= 600; k++) begin
            step();
            if (log_wr_en) begin
                wk.push_back(k);
                wd.push_back(log_data);
            end
            if (log_rd_start) rs_k = k;
        end
        checks++;
        if (wk.size() != 3) begin
            errors++;
            $display("FAIL keep_count: writes=%0d want 3", wk.size());
        end else begin
            checks++;
            if (wk[0] != 1 || wk[1] != 256 || wk[2] != 511) begin
                errors++;
                $display("FAIL keep_time: at %0d %0d %0d want 1 256 511",
                         wk[0], wk[1], wk[2]);
            end
            checks++;
            if (wd[0] !== {8'd0, 28'hABC} || wd[1] !== {8'hFF, 28'hABC} ||
                wd[2] !== {8'hFF, 28'hABC}) begin
                errors++;
                $display("FAIL keep_data: %h %h %h want delta 00 ff ff",
                         wd[0], wd[1], wd[2]);
            end
        end
        checks++;
        if (rs_k != 512) begin
            errors++;
            $display("FAIL keep_rs: at=%0d want 512", rs_k);
        end
        probe_valid = 1'b0;
    endtask

    task automatic test_full(input logic [9:0] pc);
        int nwr = 0;
        int nrs = 0;
        int last_k = -1;
        int rs_k = -1;
        do_arm(pc);
        probe_valid = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            probe = 28'(k + 100);
            step();
            if (log_wr_en) begin
                nwr++;
                last_k = k;
            end
            if (log_rd_start) begin
                nrs++;
                rs_k = k;
            end
        end
        checks++;
        if (nwr != 512 || word_cnt !== 10'd512) begin
            errors++;
            $display("FAIL full_%0d: writes=%0d wc=%0d want 512 512",
                     pc, nwr, word_cnt);
        end
        checks++;
        if (nrs != 1 || rs_k != last_k + 1 || state !== 2'd3) begin
            errors++;
            $display("FAIL full_rs_%0d: n=%0d at=%0d last=%0d st=%0d want 1 last+1 3",
                     pc, nrs, rs_k, last_k, state);
        end
        probe_valid = 1'b0;
    endtask

    task automatic test_abort();
        int bad = 0;
        do_arm(10'd8);
        probe_valid = 1'b1;
        probe = 28'd1;
        step();
        probe = 28'd2;
        step();
        probe_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (state !== 2'd0 || word_cnt !== 10'd2) begin
            errors++;
            $display("FAIL abort_idle: st=%0d wc=%0d want 0 2", state, word_cnt);
        end
        probe_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            probe = 28'(k + 50);
            step();
            if (log_rd_start || log_wr_en) bad++;
        end
        checks++;
        if (bad != 0 || word_cnt !== 10'd2) begin
            errors++;
            $display("FAIL abort_quiet: events=%0d wc=%0d want 0 2", bad, word_cnt);
        end
        do_arm(10'd1);
        step();
        step();
        probe_valid = 1'b0;
        abort = 1'b1;
        step();
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL abort_in_done: st=%0d want 3", state);
        end
        arm = 1'b1;
        step();
        arm = 1'b0;
        abort = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL arm_abort: st=%0d want 0", state);
        end
    endtask

    task automatic test_async_rst();
        int bad = 0;
        logic pre_wr;
        do_arm(10'd20);
        probe_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            probe = 28'(k + 7);
            step();
        end
        pre_wr = log_wr_en;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pre_wr !== 1'b1 || state !== 2'd0 || log_wr_en !== 1'b0 ||
            log_data !== 36'd0 || word_cnt !== 10'd0 || log_rd_start !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: pre=%b st=%0d wr=%b d=%h wc=%0d rs=%b want 1 0 0 0 0 0",
                     pre_wr, state, log_wr_en, log_data, word_cnt, log_rd_start);
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            probe = 28'(k + 200);
            step();
            if (log_rd_start || log_wr_en || state !== 2'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL async_after: events=%0d want 0", bad);
        end
        probe_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_keepalive();
        test_full(10'd0);
        test_full(10'd1023);
        test_abort();
        test_async_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
